// File: rtl/core_pkg.sv
// Shared core types for the fetch/imem interface: widths, the NOP used for faulted
// slots, and the response record carried through the imem response pipe (IMEM_PARITY_EN adds perr).
package core_pkg;
  localparam int XLEN        = 32;
  localparam int FETCH_WIDTH = 2;
  localparam logic [XLEN-1:0] NOP_INSTR = 32'h00000013;

  typedef struct packed {
    logic                              valid;
    logic [FETCH_WIDTH-1:0][XLEN-1:0]  pc;
    logic [FETCH_WIDTH-1:0][XLEN-1:0]  rdata;
    logic [FETCH_WIDTH-1:0]            err;
`ifdef IMEM_PARITY_EN
    logic [FETCH_WIDTH-1:0]            perr;
`endif
  } imem_resp_t;
endpackage

// File: rtl/imem_resp_pipe.sv
// STAGES-deep delay line for imem responses. A flush kills every stage's valid bit;
// payload only advances alongside a surviving valid, so data holds while idle.
module imem_resp_pipe
  import core_pkg::*;
#(
  parameter int STAGES = 0
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       flush,
  input  imem_resp_t in_resp,
  output imem_resp_t out_resp
);

  if (STAGES == 0) begin : g_pass
    logic pass_unused;
    assign pass_unused = ^{clk, reset_n, flush};
    assign out_resp    = in_resp;
  end else begin : g_stages
    imem_resp_t stage_q [STAGES];
    imem_resp_t stage_d [STAGES];
    imem_resp_t chain   [STAGES+1];

    assign chain[0] = in_resp;
    for (genvar g = 0; g < STAGES; g++) begin : g_chain
      assign chain[g+1] = stage_q[g];
    end

    always_comb begin
      for (int i = 0; i < STAGES; i++) begin
        stage_d[i]       = stage_q[i];
        stage_d[i].valid = 1'b0;
        if (chain[i].valid && !flush) stage_d[i] = chain[i];
      end
    end

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        for (int i = 0; i < STAGES; i++) stage_q[i] <= '0;
      end else begin
        for (int i = 0; i < STAGES; i++) stage_q[i] <= stage_d[i];
      end
    end

    assign out_resp = chain[STAGES];
  end

endmodule

// File: rtl/imem_responder.sv
// Dual-read-port instruction memory with program-load port and redirect flush.
// Optional IMEM_PARITY_EN adds a per-word even-parity bit, imem_perr and prog_perr_inj.
module imem_responder
  import core_pkg::*;
#(
  parameter int    ADDR_WIDTH  = XLEN,
  parameter int    INSTR_WIDTH = XLEN,
  parameter int    FETCH_W     = FETCH_WIDTH,
  parameter int    DEPTH       = 256,
  parameter int    LATENCY     = 1,
  parameter string INIT_FILE   = ""
) (
  input  logic                                clk,
  input  logic                                reset_n,
  input  logic                                imem_ren,
  input  logic [ADDR_WIDTH-1:0]               imem_addr0,
  input  logic [ADDR_WIDTH-1:0]               imem_addr1,
  input  logic                                flush,
  input  logic                                prog_we,
  input  logic [ADDR_WIDTH-1:0]               prog_addr,
  input  logic [INSTR_WIDTH-1:0]              prog_wdata,
`ifdef IMEM_PARITY_EN
  input  logic                                prog_perr_inj,
  output logic [FETCH_W-1:0]                  imem_perr,
`endif
  output logic                                imem_valid,
  output logic [INSTR_WIDTH-1:0]              imem_rdata0,
  output logic [INSTR_WIDTH-1:0]              imem_rdata1,
  output logic [FETCH_W-1:0][ADDR_WIDTH-1:0]  imem_pc,
  output logic [FETCH_W-1:0]                  imem_err
);

  localparam int IDXW = $clog2(DEPTH);
  // Storage is filled through the program-load port; the image name is kept for interface parity.
  localparam bit init_file_unused = (INIT_FILE != "");

  function automatic logic addr_fault(input logic [ADDR_WIDTH-1:0] a);
    return (a[1:0] != 2'b00) || ((a >> 2) >= ADDR_WIDTH'(DEPTH));
  endfunction

  logic [INSTR_WIDTH-1:0]              mem_q [DEPTH];
  logic [FETCH_W-1:0][ADDR_WIDTH-1:0]  rd_addr;
  logic [FETCH_W-1:0][IDXW-1:0]        rd_idx;
  logic [FETCH_W-1:0]                  rd_fault;
  logic [FETCH_W-1:0][INSTR_WIDTH-1:0] rd_word;
  logic                                wr_en;
  logic [IDXW-1:0]                     wr_idx;
  imem_resp_t                          resp_d, resp_q, out_resp;

  assign rd_addr[0] = imem_addr0;
  assign rd_addr[1] = imem_addr1;

  always_comb begin
    for (int i = 0; i < FETCH_W; i++) begin
      rd_idx[i]   = rd_addr[i][IDXW+1:2];
      rd_fault[i] = addr_fault(rd_addr[i]);
      rd_word[i]  = rd_fault[i] ? INSTR_WIDTH'(NOP_INSTR) : mem_q[rd_idx[i]];
    end
  end

  assign wr_en  = prog_we && !addr_fault(prog_addr);
  assign wr_idx = prog_addr[IDXW+1:2];

  // Reads sample mem_q before this edge's write lands: a colliding read sees old data.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_idx] <= prog_wdata;
  end

`ifdef IMEM_PARITY_EN
  logic               mem_par_q [DEPTH];
  logic [FETCH_W-1:0] rd_perr;

  always_ff @(posedge clk) begin
    if (wr_en) mem_par_q[wr_idx] <= (^prog_wdata) ^ prog_perr_inj;
  end

  always_comb begin
    for (int i = 0; i < FETCH_W; i++) begin
      rd_perr[i] = !rd_fault[i] && ((^mem_q[rd_idx[i]]) ^ mem_par_q[rd_idx[i]]);
    end
  end
`endif

  // First response stage: always accepts the current request, even under flush.
  always_comb begin
    resp_d       = resp_q;
    resp_d.valid = imem_ren;
    if (imem_ren) begin
      for (int i = 0; i < FETCH_W; i++) begin
        resp_d.pc[i]    = rd_addr[i];
        resp_d.rdata[i] = rd_word[i];
        resp_d.err[i]   = rd_fault[i];
      end
`ifdef IMEM_PARITY_EN
      resp_d.perr = rd_perr;
`endif
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) resp_q <= '0;
    else          resp_q <= resp_d;
  end

  imem_resp_pipe #(
    .STAGES (LATENCY - 1)
  ) u_pipe (
    .clk      (clk),
    .reset_n  (reset_n),
    .flush    (flush),
    .in_resp  (resp_q),
    .out_resp (out_resp)
  );

  assign imem_valid  = out_resp.valid;
  assign imem_rdata0 = out_resp.rdata[0];
  assign imem_rdata1 = out_resp.rdata[1];
  assign imem_pc     = out_resp.pc;
  assign imem_err    = out_resp.err;
`ifdef IMEM_PARITY_EN
  assign imem_perr   = out_resp.perr;
`endif

endmodule
